// File: rtl/lc3b_types.sv
// Shared issue-queue types: invalid ROB tag, entry layout and CDB bundle at default widths.
package lc3b_types;

  localparam int unsigned ROB_IDX_W_DEF = 3;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned OP_W_DEF      = 4;
  localparam int unsigned CDB_PORTS_DEF = 2;

  // All-ones tag marks an operand whose value is already present.
  localparam logic [ROB_IDX_W_DEF-1:0] ROB_ID_INVALID = '1;

  typedef struct packed {
    logic                     busy;
    logic [OP_W_DEF-1:0]      op;
    logic [DATA_W_DEF-1:0]    vj;
    logic [DATA_W_DEF-1:0]    vk;
    logic [ROB_IDX_W_DEF-1:0] qj;
    logic [ROB_IDX_W_DEF-1:0] qk;
    logic                     rj;
    logic                     rk;
    logic [ROB_IDX_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0]    pc;
  } lc3b_iq_entry;

  typedef struct packed {
    logic                     valid;
    logic [ROB_IDX_W_DEF-1:0] tag;
    logic [DATA_W_DEF-1:0]    value;
  } lc3b_cdb_port;

  typedef lc3b_cdb_port [CDB_PORTS_DEF-1:0] lc3b_cdb_array;

endpackage

// File: rtl/iq_age_select.sv
// Age matrix tracking allocation order plus oldest-ready one-hot picker.
module iq_age_select #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [SIZE-1:0] busy,
  input  logic [SIZE-1:0] ready,
  input  logic [SIZE-1:0] alloc_oh,
  input  logic [SIZE-1:0] free_oh,
  output logic [SIZE-1:0] grant
);

  // r_older[j][i] set means slot j was allocated before slot i.
  logic [SIZE-1:0] r_older     [SIZE];
  logic [SIZE-1:0] w_older_nxt [SIZE];
  logic [SIZE-1:0] w_blocked;

  always_comb begin
    for (int unsigned j = 0; j < SIZE; j++) w_older_nxt[j] = r_older[j];
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (alloc_oh[i]) begin
        for (int unsigned j = 0; j < SIZE; j++) w_older_nxt[j][i] = (j != i) && busy[j];
        w_older_nxt[i] = '0;
      end
    end
    // Freeing is applied last so a slot issued this edge never counts as older.
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (free_oh[i]) begin
        w_older_nxt[i] = '0;
        for (int unsigned j = 0; j < SIZE; j++) w_older_nxt[j][i] = 1'b0;
      end
    end
    if (flush) begin
      for (int unsigned j = 0; j < SIZE; j++) w_older_nxt[j] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < SIZE; j++) r_older[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < SIZE; j++) r_older[j] <= w_older_nxt[j];
    end
  end

  always_comb begin
    w_blocked = '0;
    grant     = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      for (int unsigned j = 0; j < SIZE; j++) begin
        if (ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
      grant[i] = ready[i] && !w_blocked[i];
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Issue queue: internal slot allocation, multi-port CDB wakeup with allocate bypass,
// oldest-ready issue through an age matrix with a valid/ready handshake.
module issue_queue
  import lc3b_types::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned ROB_IDX_W = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OP_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [OP_W-1:0]               alloc_op,
  input  logic [DATA_W-1:0]             alloc_vj,
  input  logic [DATA_W-1:0]             alloc_vk,
  input  logic [ROB_IDX_W-1:0]          alloc_qj,
  input  logic [ROB_IDX_W-1:0]          alloc_qk,
  input  logic [ROB_IDX_W-1:0]          alloc_dest,
  input  logic [DATA_W-1:0]             alloc_pc,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [OP_W-1:0]               issue_op,
  output logic [DATA_W-1:0]             issue_vj,
  output logic [DATA_W-1:0]             issue_vk,
  output logic [ROB_IDX_W-1:0]          issue_dest,
  output logic [DATA_W-1:0]             issue_pc,
  input  logic                          flush,
  output logic [$clog2(SIZE+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W = $clog2(SIZE + 1);
  localparam logic [ROB_IDX_W-1:0] TAG_INVALID = '1;

  logic [SIZE-1:0]      r_busy, r_rj, r_rk;
  logic [OP_W-1:0]      r_op   [SIZE];
  logic [DATA_W-1:0]    r_vj   [SIZE];
  logic [DATA_W-1:0]    r_vk   [SIZE];
  logic [ROB_IDX_W-1:0] r_qj   [SIZE];
  logic [ROB_IDX_W-1:0] r_qk   [SIZE];
  logic [ROB_IDX_W-1:0] r_dest [SIZE];
  logic [DATA_W-1:0]    r_pc   [SIZE];

  logic [ROB_IDX_W-1:0] w_cdb_tag [CDB_PORTS];
  logic [DATA_W-1:0]    w_cdb_val [CDB_PORTS];
  logic [SIZE-1:0]      w_alloc_oh, w_alloc_fire_oh, w_free_oh, w_ready, w_grant;
  logic                 w_found, w_alloc_fire, w_issue_fire;
  logic                 w_aj_hit, w_ak_hit;
  logic [DATA_W-1:0]    w_aj_val, w_ak_val;
  logic [SIZE-1:0]      w_wj_hit, w_wk_hit;
  logic [DATA_W-1:0]    w_wj_val [SIZE];
  logic [DATA_W-1:0]    w_wk_val [SIZE];

  always_comb begin
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      w_cdb_tag[p] = cdb_tag[p*ROB_IDX_W +: ROB_IDX_W];
      w_cdb_val[p] = cdb_value[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_alloc_oh = '0;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!r_busy[i] && !w_found) begin
        w_alloc_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign alloc_ready     = |(~r_busy);
  assign w_ready         = r_busy & r_rj & r_rk;
  assign issue_valid     = |w_ready;
  assign w_alloc_fire    = alloc_valid && alloc_ready && !flush;
  assign w_issue_fire    = issue_valid && issue_ready && !flush;
  assign w_alloc_fire_oh = w_alloc_fire ? w_alloc_oh : '0;
  assign w_free_oh       = w_issue_fire ? w_grant : '0;

  // CDB matching: ports scanned low to high and the first hit is kept.
  always_comb begin
    w_aj_hit = 1'b0;
    w_ak_hit = 1'b0;
    w_aj_val = '0;
    w_ak_val = '0;
    w_wj_hit = '0;
    w_wk_hit = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_wj_val[i] = '0;
      w_wk_val[i] = '0;
    end
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p]) begin
        if (!w_aj_hit && alloc_qj != TAG_INVALID && w_cdb_tag[p] == alloc_qj) begin
          w_aj_hit = 1'b1;
          w_aj_val = w_cdb_val[p];
        end
        if (!w_ak_hit && alloc_qk != TAG_INVALID && w_cdb_tag[p] == alloc_qk) begin
          w_ak_hit = 1'b1;
          w_ak_val = w_cdb_val[p];
        end
        for (int unsigned i = 0; i < SIZE; i++) begin
          if (r_busy[i] && !w_wj_hit[i] && r_qj[i] != TAG_INVALID && w_cdb_tag[p] == r_qj[i]) begin
            w_wj_hit[i] = 1'b1;
            w_wj_val[i] = w_cdb_val[p];
          end
          if (r_busy[i] && !w_wk_hit[i] && r_qk[i] != TAG_INVALID && w_cdb_tag[p] == r_qk[i]) begin
            w_wk_hit[i] = 1'b1;
            w_wk_val[i] = w_cdb_val[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_rj   <= '0;
      r_rk   <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        r_op[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= TAG_INVALID;
        r_qk[i]   <= TAG_INVALID;
        r_dest[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
      r_rj   <= '0;
      r_rk   <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        r_qj[i] <= TAG_INVALID;
        r_qk[i] <= TAG_INVALID;
      end
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (w_alloc_fire_oh[i]) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= alloc_op;
          r_dest[i] <= alloc_dest;
          r_pc[i]   <= alloc_pc;
          r_vj[i]   <= w_aj_hit ? w_aj_val : alloc_vj;
          r_vk[i]   <= w_ak_hit ? w_ak_val : alloc_vk;
          r_qj[i]   <= w_aj_hit ? TAG_INVALID : alloc_qj;
          r_qk[i]   <= w_ak_hit ? TAG_INVALID : alloc_qk;
          r_rj[i]   <= w_aj_hit || (alloc_qj == TAG_INVALID);
          r_rk[i]   <= w_ak_hit || (alloc_qk == TAG_INVALID);
        end else begin
          if (w_free_oh[i]) r_busy[i] <= 1'b0;
          if (w_wj_hit[i]) begin
            r_vj[i] <= w_wj_val[i];
            r_qj[i] <= TAG_INVALID;
            r_rj[i] <= 1'b1;
          end
          if (w_wk_hit[i]) begin
            r_vk[i] <= w_wk_val[i];
            r_qk[i] <= TAG_INVALID;
            r_rk[i] <= 1'b1;
          end
        end
      end
    end
  end

  iq_age_select #(
    .SIZE(SIZE)
  ) u_age_select (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .busy    (r_busy),
    .ready   (w_ready),
    .alloc_oh(w_alloc_fire_oh),
    .free_oh (w_free_oh),
    .grant   (w_grant)
  );

  always_comb begin
    issue_op   = '0;
    issue_vj   = '0;
    issue_vk   = '0;
    issue_dest = '0;
    issue_pc   = '0;
    occupancy  = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (w_grant[i]) begin
        issue_op   = r_op[i];
        issue_vj   = r_vj[i];
        issue_vk   = r_vk[i];
        issue_dest = r_dest[i];
        issue_pc   = r_pc[i];
      end
      occupancy = occupancy + OCC_W'(r_busy[i]);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue at default parameters.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_op;
  logic [15:0] alloc_vj, alloc_vk, alloc_pc;
  logic [2:0]  alloc_qj, alloc_qk, alloc_dest;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [15:0] issue_vj, issue_vk, issue_pc;
  logic [2:0]  issue_dest;
  logic        flush;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_queue #(
    .SIZE(4), .CDB_PORTS(2), .ROB_IDX_W(3), .DATA_W(16), .OP_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_dest(issue_dest), .issue_pc(issue_pc),
    .flush(flush), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic v, input logic [2:0] qj, input logic [2:0] qk,
                           input logic [15:0] vj, input logic [15:0] vk,
                           input logic [15:0] pc, input logic [2:0] dest);
    alloc_valid = v;
    alloc_qj    = qj;
    alloc_qk    = qk;
    alloc_vj    = vj;
    alloc_vk    = vk;
    alloc_pc    = pc;
    alloc_op    = pc[3:0];
    alloc_dest  = dest;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_occupancy",   32'(occupancy),   32'd0);
    chk("rst_issue_pc",    32'(issue_pc),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill four ready entries, then drain in allocation order
    for (int n = 0; n < 4; n++) begin
      set_alloc(1'b1, 3'd7, 3'd7, 16'(16'h10 + n), 16'(16'h20 + n), 16'(16'h100 + n), 3'(n));
      step();
      chk("fill_occ",   32'(occupancy),   32'(n + 1));
      chk("fill_ready", 32'(alloc_ready), (n < 3) ? 32'd1 : 32'd0);
    end
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    issue_ready = 1'b1;
    chk("drain_valid0", 32'(issue_valid), 32'd1);
    chk("drain_pc0",    32'(issue_pc),    32'h100);
    chk("drain_vj0",    32'(issue_vj),    32'h10);
    chk("drain_vk0",    32'(issue_vk),    32'h20);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("drain_occ",   32'(occupancy),   32'(3 - n));
      chk("drain_ready", 32'(alloc_ready), 32'd1);
      if (n < 3) begin
        chk("drain_pc",   32'(issue_pc),   32'(16'h101 + n));
        chk("drain_dest", 32'(issue_dest), 32'(n + 1));
        if (n == 0) chk("drain_op", 32'(issue_op), 32'd1);
      end else begin
        chk("drain_empty", 32'(issue_valid), 32'd0);
      end
    end

    // Younger ready entry overtakes older one waiting on tag 2
    issue_ready = 1'b0;
    set_alloc(1'b1, 3'd2, 3'd7, 16'h0, 16'h000A, 16'h200, 3'd1);
    step();
    chk("wait_not_ready", 32'(issue_valid), 32'd0);
    set_alloc(1'b1, 3'd7, 3'd7, 16'h0011, 16'h0, 16'h201, 3'd2);
    step();
    chk("b_valid", 32'(issue_valid), 32'd1);
    chk("b_pc",    32'(issue_pc),    32'h201);
    chk("b_occ",   32'(occupancy),   32'd2);
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd2}; cdb_value = {16'h0000, 16'h1234};
    issue_ready = 1'b1;
    step();
    cdb_valid = 2'b00;
    chk("a_valid", 32'(issue_valid), 32'd1);
    chk("a_pc",    32'(issue_pc),    32'h200);
    chk("a_vj",    32'(issue_vj),    32'h1234);
    chk("a_vk",    32'(issue_vk),    32'h000A);
    chk("a_occ",   32'(occupancy),   32'd1);
    step();
    chk("a_gone_valid", 32'(issue_valid), 32'd0);
    chk("a_gone_occ",   32'(occupancy),   32'd0);

    // Allocate-time bypass from CDB port 1
    set_alloc(1'b1, 3'd7, 3'd5, 16'h0033, 16'h0, 16'h250, 3'd3);
    cdb_valid = 2'b10; cdb_tag = {3'd5, 3'd0}; cdb_value = {16'hBEEF, 16'h0000};
    step();
    cdb_valid = 2'b00;
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("byp_valid", 32'(issue_valid), 32'd1);
    chk("byp_vk",    32'(issue_vk),    32'hBEEF);
    chk("byp_vj",    32'(issue_vj),    32'h0033);
    step();
    chk("byp_occ", 32'(occupancy), 32'd0);

    // Full queue: alloc blocked, issue frees a slot only for the next edge
    issue_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      set_alloc(1'b1, 3'd7, 3'd7, 16'h0, 16'h0, 16'(16'h300 + n), 3'(n));
      step();
    end
    chk("full_ready", 32'(alloc_ready), 32'd0);
    set_alloc(1'b1, 3'd7, 3'd7, 16'h0, 16'h0, 16'h3FF, 3'd7);
    step();
    chk("full_ignored_occ", 32'(occupancy), 32'd4);
    chk("full_pc",          32'(issue_pc),  32'h300);
    issue_ready = 1'b1;
    step();
    chk("full_issue_occ",   32'(occupancy),   32'd3);
    chk("full_issue_ready", 32'(alloc_ready), 32'd1);
    chk("full_issue_pc",    32'(issue_pc),    32'h301);
    issue_ready = 1'b0;
    step();
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("late_alloc_occ", 32'(occupancy), 32'd4);
    chk("late_alloc_pc",  32'(issue_pc),  32'h301);
    issue_ready = 1'b1;
    step();
    chk("reuse_pc1", 32'(issue_pc), 32'h302);
    step();
    chk("reuse_pc2", 32'(issue_pc), 32'h303);
    step();
    chk("reuse_pc3", 32'(issue_pc), 32'h3FF);
    chk("reuse_op3", 32'(issue_op), 32'hF);
    step();
    chk("reuse_empty", 32'(issue_valid), 32'd0);
    chk("reuse_occ",   32'(occupancy),   32'd0);

    // Two ports wake two entries in one cycle; the older issues first
    issue_ready = 1'b0;
    set_alloc(1'b1, 3'd1, 3'd7, 16'h0, 16'h0, 16'h500, 3'd4);
    step();
    set_alloc(1'b1, 3'd3, 3'd7, 16'h0, 16'h0, 16'h501, 3'd5);
    step();
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("dual_wait", 32'(issue_valid), 32'd0);
    cdb_valid = 2'b11; cdb_tag = {3'd1, 3'd3}; cdb_value = {16'h00B1, 16'h00A3};
    step();
    cdb_valid = 2'b00;
    issue_ready = 1'b1;
    chk("dual_pc0", 32'(issue_pc), 32'h500);
    chk("dual_vj0", 32'(issue_vj), 32'h00B1);
    step();
    chk("dual_pc1", 32'(issue_pc), 32'h501);
    chk("dual_vj1", 32'(issue_vj), 32'h00A3);
    step();
    chk("dual_occ", 32'(occupancy), 32'd0);

    // Flush beats a simultaneous alloc and issue
    issue_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_alloc(1'b1, 3'd7, 3'd7, 16'h0, 16'h0, 16'(16'h600 + n), 3'(n));
      step();
    end
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    set_alloc(1'b1, 3'd7, 3'd7, 16'h0, 16'h0, 16'h6FF, 3'd6);
    issue_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue_ready = 1'b0;
    chk("flush_occ",   32'(occupancy),   32'd0);
    chk("flush_valid", 32'(issue_valid), 32'd0);
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    set_alloc(1'b1, 3'd7, 3'd7, 16'h0, 16'h0, 16'h700, 3'd0);
    step();
    step();
    set_alloc(1'b0, 3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_occ",   32'(occupancy),   32'd0);
    chk("async_valid", 32'(issue_valid), 32'd0);
    chk("async_ready", 32'(alloc_ready), 32'd1);
    chk("async_pc",    32'(issue_pc),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
